rsync_level: RTL and testbench

RSYNC_LEVEL -- requirements
Module: rsync_level

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/sync_chain.sv | 30 +++
 rtl/rsync_level.sv | 101 ++++++++++
 tb/tb_rsync_level.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer constants and gray/binary conversion helpers,
// used by the write-side, read-side and level logic.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF = 3;
  localparam int DEPTH_DEF     = 1 << PTR_WIDTH_DEF;
  localparam int SYNC_DEF      = 2;
  localparam int PTR_MAX_W     = 32;

  // Callers zero-extend; leading zeros convert to zeros in both directions.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(
    input logic [PTR_MAX_W-1:0] g
  );
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(
    input logic [PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer: STAGES plain flops, no logic between them.
// Shared by the write->read and read->write pointer crossings.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stg_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/rsync_level.sv
// Read-side write-pointer sync, occupancy level and error flags.
// Optional saturating underflow counter: RSYNC_UNDERFLOW_CNT_EN.
module rsync_level
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH     = PTR_WIDTH_DEF,
  parameter int SYNC_STAGES   = SYNC_DEF,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic [PTR_WIDTH:0] g_wptr,
  input  logic [PTR_WIDTH:0] b_rptr,
  input  logic               r_en,
  input  logic               empty,
  input  logic               clr_sticky,
  output logic [PTR_WIDTH:0] g_wptr_sync,
  output logic [PTR_WIDTH:0] b_wptr_sync,
  output logic [PTR_WIDTH:0] rd_level,
  output logic               almost_empty,
  output logic               underflow,
  output logic               underflow_sticky,
  output logic               ptr_err_sticky
`ifdef RSYNC_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]         underflow_cnt
`endif
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << PTR_WIDTH);
  localparam logic [PW-1:0] AE_T  = PW'(AEMPTY_THRESH);

  logic [PW-1:0]        b_wptr_q;
  logic [PW-1:0]        b_wptr_d;
  logic [PW-1:0]        level_q;
  logic [PW-1:0]        diff;
  logic [PTR_MAX_W-1:0] g2b;
  logic                 ptr_err_ev;
  logic                 uf_ev;
  logic                 uf_q;
  logic                 uf_stk_q;
  logic                 err_stk_q;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_i  (rclk),
    .rst_ni (rrst_n),
    .d_i    (g_wptr),
    .q_o    (g_wptr_sync)
  );

  assign g2b        = gray2bin(PTR_MAX_W'(g_wptr_sync));
  assign b_wptr_d   = g2b[PW-1:0];
  assign diff       = b_wptr_q - b_rptr;
  assign ptr_err_ev = diff > DEPTH;
  assign uf_ev      = r_en & empty;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_wptr_q  <= '0;
      level_q   <= '0;
      uf_q      <= 1'b0;
      uf_stk_q  <= 1'b0;
      err_stk_q <= 1'b0;
    end else begin
      b_wptr_q  <= b_wptr_d;
      // An impossible occupancy keeps the last trusted level.
      if (!ptr_err_ev) level_q <= diff;
      uf_q      <= uf_ev;
      uf_stk_q  <= uf_ev | (uf_stk_q & ~clr_sticky);
      err_stk_q <= ptr_err_ev | (err_stk_q & ~clr_sticky);
    end
  end

`ifdef RSYNC_UNDERFLOW_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else if (clr_sticky) begin
      cnt_q <= '0;
    end else if (uf_ev && cnt_q != 8'hff) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign underflow_cnt = cnt_q;
`endif

  assign b_wptr_sync      = b_wptr_q;
  assign rd_level         = level_q;
  assign almost_empty     = level_q <= AE_T;
  assign underflow        = uf_q;
  assign underflow_sticky = uf_stk_q;
  assign ptr_err_sticky   = err_stk_q;

endmodule

// File: tb/tb_rsync_level.sv
// Directed bench for rsync_level (PTR_WIDTH=3, SYNC_STAGES=2).
// Counter checks run when RSYNC_UNDERFLOW_CNT_EN is defined.
module tb_rsync_level;

  logic       rclk;
  logic       rrst_n;
  logic [3:0] g_wptr;
  logic [3:0] b_rptr;
  logic       r_en;
  logic       empty;
  logic       clr_sticky;
  logic [3:0] g_wptr_sync;
  logic [3:0] b_wptr_sync;
  logic [3:0] rd_level;
  logic       almost_empty;
  logic       underflow;
  logic       underflow_sticky;
  logic       ptr_err_sticky;
`ifdef RSYNC_UNDERFLOW_CNT_EN
  logic [7:0] underflow_cnt;
`endif

  int n_chk;
  int n_err;
  int n_pulse;

  rsync_level #(
    .PTR_WIDTH     (3),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (2)
  ) dut (
    .rclk             (rclk),
    .rrst_n           (rrst_n),
    .g_wptr           (g_wptr),
    .b_rptr           (b_rptr),
    .r_en             (r_en),
    .empty            (empty),
    .clr_sticky       (clr_sticky),
    .g_wptr_sync      (g_wptr_sync),
    .b_wptr_sync      (b_wptr_sync),
    .rd_level         (rd_level),
    .almost_empty     (almost_empty),
    .underflow        (underflow),
    .underflow_sticky (underflow_sticky),
    .ptr_err_sticky   (ptr_err_sticky)
`ifdef RSYNC_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt    (underflow_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      @(negedge rclk);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rrst_n = 1'b0;
    g_wptr = 4'b0110;
    b_rptr = 4'd0;
    r_en = 1'b0;
    empty = 1'b0;
    clr_sticky = 1'b0;

    // reset state
    tick(3);
    chk("rst_gsync", g_wptr_sync, 0);
    chk("rst_bsync", b_wptr_sync, 0);
    chk("rst_level", rd_level, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_uf", underflow, 0);
    chk("rst_ufs", underflow_sticky, 0);
    chk("rst_err", ptr_err_sticky, 0);
`ifdef RSYNC_UNDERFLOW_CNT_EN
    chk("rst_cnt", underflow_cnt, 0);
`endif
    rrst_n = 1'b1;
    tick(3);
    chk("rel_bsync3", b_wptr_sync, 4);
    chk("rel_level3", rd_level, 0);
    chk("rel_ae3", almost_empty, 1);
    tick();
    chk("rel_level4", rd_level, 4);
    chk("rel_ae4", almost_empty, 0);

    // latency 0 -> 1
    g_wptr = 4'b0000;
    tick(4);
    chk("lat_l0", rd_level, 0);
    g_wptr = 4'b0001;
    tick();
    chk("lat_g1", g_wptr_sync, 0);
    tick();
    chk("lat_g2", g_wptr_sync, 1);
    chk("lat_b2", b_wptr_sync, 0);
    tick();
    chk("lat_b3", b_wptr_sync, 1);
    chk("lat_l3", rd_level, 0);
    tick();
    chk("lat_l4", rd_level, 1);
    chk("lat_ae4", almost_empty, 1);

    // threshold boundary
    g_wptr = 4'b0011;
    tick(4);
    chk("ae_l2", rd_level, 2);
    chk("ae_2", almost_empty, 1);
    g_wptr = 4'b0010;
    tick(4);
    chk("ae_l3", rd_level, 3);
    chk("ae_3", almost_empty, 0);

    // wrap: binary 10 -> 0 -> 1 against read pointer 15
    b_rptr = 4'd8;
    g_wptr = 4'b1111;
    tick(4);
    chk("wrap_l10", rd_level, 2);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("wrap_clr", ptr_err_sticky, 0);
    g_wptr = 4'b0000;
    tick(3);
    b_rptr = 4'd15;
    tick();
    chk("wrap_l0", rd_level, 1);
    g_wptr = 4'b0001;
    tick(4);
    chk("wrap_l1", rd_level, 2);
    chk("wrap_ae", almost_empty, 1);
    chk("wrap_err", ptr_err_sticky, 0);

    // full and illegal occupancy
    b_rptr = 4'd0;
    g_wptr = 4'b1100;
    tick(4);
    chk("full_l8", rd_level, 8);
    chk("full_err", ptr_err_sticky, 0);
    chk("full_ae", almost_empty, 0);
    g_wptr = 4'b1101;
    tick(4);
    chk("ovf_err", ptr_err_sticky, 1);
    chk("ovf_hold", rd_level, 8);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("ovf_clr_ev", ptr_err_sticky, 1);
    g_wptr = 4'b1100;
    tick(4);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("ovf_clr", ptr_err_sticky, 0);
    chk("ovf_l8", rd_level, 8);

    // underflow
    empty = 1'b1;
    r_en = 1'b1;
    n_pulse = 0;
    tick();
    chk("uf_first", underflow, 1);
    n_pulse += int'(underflow);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_pulse += int'(underflow);
    end
    r_en = 1'b0;
    tick();
    n_pulse += int'(underflow);
    chk("uf_pulses", n_pulse, 3);
    chk("uf_end", underflow, 0);
    chk("uf_stk", underflow_sticky, 1);
`ifdef RSYNC_UNDERFLOW_CNT_EN
    chk("uf_cnt3", underflow_cnt, 3);
`endif
    clr_sticky = 1'b1;
    r_en = 1'b1;
    tick();
    chk("ufc_pulse", underflow, 1);
    chk("ufc_stk", underflow_sticky, 1);
`ifdef RSYNC_UNDERFLOW_CNT_EN
    chk("ufc_cnt", underflow_cnt, 0);
`endif
    r_en = 1'b0;
    tick();
    clr_sticky = 1'b0;
    chk("ufc_clr", underflow_sticky, 0);
    chk("ufc_nopulse", underflow, 0);
    empty = 1'b0;
    r_en = 1'b1;
    tick();
    chk("uf_notempty", underflow, 0);
    chk("uf_notempty_s", underflow_sticky, 0);
    r_en = 1'b0;

`ifdef RSYNC_UNDERFLOW_CNT_EN
    empty = 1'b1;
    r_en = 1'b1;
    tick(300);
    chk("cnt_sat", underflow_cnt, 255);
    r_en = 1'b0;
    empty = 1'b0;
`endif

    // reset mid-operation, released off-edge
    empty = 1'b1;
    r_en = 1'b1;
    g_wptr = 4'b1111;
    tick();
    chk("mid_uf", underflow, 1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("mid_uf0", underflow, 0);
    chk("mid_ufs0", underflow_sticky, 0);
    chk("mid_g0", g_wptr_sync, 0);
    chk("mid_l0", rd_level, 0);
    chk("mid_ae", almost_empty, 1);
    tick();
    chk("mid_hold", underflow, 0);
    r_en = 1'b0;
    empty = 1'b0;
    g_wptr = 4'b0110;
    #3;
    rrst_n = 1'b1;
    tick(4);
    chk("mid_level", rd_level, 4);
    chk("mid_err", ptr_err_sticky, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
